// File: rtl/mult_acc_algoritmico.sv
// Sequential signed multiply-accumulate, radix-2 Booth.
// Prod = MulA*MulB + Addend, one multiplier bit per ADD/SHIFT pair.
module mult_acc_algoritmico #(
  parameter int tamanyo = 32
) (
  input  logic                           CLK,
  input  logic                           RSTa,
  input  logic                           Start,
  input  logic signed [tamanyo-1:0]      MulA,
  input  logic signed [tamanyo-1:0]      MulB,
  input  logic signed [tamanyo-1:0]      Addend,
  output logic signed [2*tamanyo-1:0]    Prod,
  output logic                           Busy,
  output logic                           Done
);

  localparam int CW = $clog2(tamanyo);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  // ACC carries one guard bit so ACC-M cannot overflow for M=-2^(n-1)
  logic signed [tamanyo:0]   r_acc;
  logic signed [tamanyo:0]   r_m;
  logic [tamanyo-1:0]        r_q;
  logic                      r_q1;
  logic [2*tamanyo-1:0]      r_c;
  logic [CW-1:0]             r_cont;

  logic [2*tamanyo-1:0]      w_sum;

  assign Busy  = (r_state != S_IDLE);
  assign w_sum = {r_acc[tamanyo-1:0], r_q} + r_c;

  // State register
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = Start ? S_ADD : S_IDLE;
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = (r_cont == '0) ? S_FIN : S_ADD;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Booth datapath and registered outputs
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      r_acc  <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_q1   <= 1'b0;
      r_c    <= '0;
      r_cont <= '0;
      Prod   <= '0;
      Done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            r_acc  <= '0;
            r_m    <= {MulA[tamanyo-1], MulA};
            r_q    <= MulB;
            r_q1   <= 1'b0;
            r_c    <= {{tamanyo{Addend[tamanyo-1]}}, Addend};
            r_cont <= CW'(tamanyo - 1);
          end
        end
        S_ADD: begin
          case ({r_q[0], r_q1})
            2'b01:   r_acc <= r_acc + r_m;
            2'b10:   r_acc <= r_acc - r_m;
            default: r_acc <= r_acc;
          endcase
        end
        S_SHIFT: begin
          {r_acc, r_q, r_q1} <= {r_acc[tamanyo], r_acc, r_q};
          r_cont             <= r_cont - CW'(1);
        end
        S_FIN: begin
          Prod <= w_sum;
          Done <= 1'b1;
        end
        default: begin
          Done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_acc_algoritmico.sv
// Directed bench for mult_acc_algoritmico.
// 8-bit instance for timing/handshake, 32-bit for range.
module tb_mult_acc_algoritmico;

  logic CLK;
  logic RSTa;

  logic        st8;
  logic [7:0]  a8, b8, c8;
  logic [15:0] p8;
  logic        y8, d8;

  logic        st32;
  logic [31:0] a32, b32, c32;
  logic [63:0] p32;
  logic        y32, d32;

  int n_cmp;
  int n_err;

  mult_acc_algoritmico #(.tamanyo(8)) u_dut8 (
    .CLK    (CLK),
    .RSTa   (RSTa),
    .Start  (st8),
    .MulA   (a8),
    .MulB   (b8),
    .Addend (c8),
    .Prod   (p8),
    .Busy   (y8),
    .Done   (d8)
  );

  mult_acc_algoritmico #(.tamanyo(32)) u_dut32 (
    .CLK    (CLK),
    .RSTa   (RSTa),
    .Start  (st32),
    .MulA   (a32),
    .MulB   (b32),
    .Addend (c32),
    .Prod   (p32),
    .Busy   (y32),
    .Done   (d32)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait8(output bit got,
                       output logic [15:0] p,
                       output int n);
    got = 1'b0;
    p   = '0;
    n   = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      n++;
      if (d8) begin
        got = 1'b1;
        p   = p8;
        break;
      end
    end
  endtask

  task automatic run8(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [7:0] c,
                      output logic [15:0] p);
    bit got;
    int n;
    a8 = a; b8 = b; c8 = c;
    st8 = 1'b1;
    tick();
    st8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    c8 = 8'($urandom);
    wait8(got, p, n);
    chk("done8_seen", 64'(got), 64'd1);
  endtask

  task automatic run32(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] c,
                       output logic [63:0] p);
    bit got;
    got = 1'b0;
    p   = '0;
    a32 = a; b32 = b; c32 = c;
    st32 = 1'b1;
    tick();
    st32 = 1'b0;
    a32 = $urandom;
    b32 = $urandom;
    c32 = $urandom;
    for (int k = 0; k < 90; k++) begin
      tick();
      if (d32) begin
        got = 1'b1;
        p   = p32;
        break;
      end
    end
    chk("done32_seen", 64'(got), 64'd1);
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] c);
    longint sa, sb, sc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sc = longint'($signed(c));
    return 64'(sa * sb + sc);
  endfunction

  initial begin
    logic [15:0] p;
    logic [63:0] q;
    bit          got;
    int          n;
    int          busy_cnt, done_cnt, done_at;
    logic [15:0] pv;
    logic [31:0] ra, rb, rc;

    n_cmp = 0;
    n_err = 0;
    RSTa = 1'b0;
    st8 = 1'b0; a8 = '0; b8 = '0; c8 = '0;
    st32 = 1'b0; a32 = '0; b32 = '0; c32 = '0;
    repeat (3) tick();
    chk("rst_prod8", 64'(p8), 64'd0);
    chk("rst_done8", 64'(d8), 64'd0);
    chk("rst_busy8", 64'(y8), 64'd0);
    chk("rst_prod32", p32, 64'd0);
    RSTa = 1'b1;
    tick();

    // 7*3+1 with latency and pulse-width measurement
    a8 = 8'd7; b8 = 8'd3; c8 = 8'd1;
    st8 = 1'b1;
    tick();
    st8 = 1'b0;
    chk("prod_hold_at_start", 64'(p8), 64'd0);
    busy_cnt = 0; done_cnt = 0; done_at = -1; pv = '0;
    for (int k = 0; k < 25; k++) begin
      if (y8) busy_cnt++;
      if (d8) begin
        done_cnt++;
        done_at = k;
        pv = p8;
      end
      tick();
    end
    chk("busy_cycles", 64'(busy_cnt), 64'd17);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("done_latency", 64'(done_at), 64'd17);
    chk("p_7x3p1", 64'(pv), 64'h0016);

    run8(8'hF9, 8'd3, 8'hFF, p);
    chk("p_m7x3m1", 64'(p), 64'hFFEA);
    run8(8'h80, 8'h80, 8'h00, p);
    chk("p_min_x_min", 64'(p), 64'h4000);
    run8(8'h80, 8'h7F, 8'h00, p);
    chk("p_min_x_max", 64'(p), 64'hC080);

    // Start during busy must be ignored
    a8 = 8'd10; b8 = 8'hFB; c8 = 8'd3;
    st8 = 1'b1;
    tick();
    st8 = 1'b0;
    repeat (5) tick();
    a8 = 8'd2; b8 = 8'd2; c8 = 8'd0;
    st8 = 1'b1;
    tick();
    st8 = 1'b0;
    wait8(got, p, n);
    chk("midstart_done", 64'(got), 64'd1);
    chk("midstart_prod", 64'(p), 64'hFFD1);
    wait8(got, p, n);
    chk("midstart_no_queue", 64'(got), 64'd0);

    // Start held high: back-to-back operations
    a8 = 8'd5; b8 = 8'hFD; c8 = 8'd2;
    st8 = 1'b1;
    tick();
    wait8(got, p, n);
    chk("b2b0_lat", 64'(n), 64'd17);
    chk("b2b0_prod", 64'(p), 64'hFFF3);
    a8 = 8'd127; b8 = 8'd127; c8 = 8'h80;
    wait8(got, p, n);
    chk("b2b1_period", 64'(n), 64'd18);
    chk("b2b1_prod", 64'(p), 64'h3E81);
    a8 = 8'h80; b8 = 8'd1; c8 = 8'd127;
    wait8(got, p, n);
    st8 = 1'b0;
    chk("b2b2_period", 64'(n), 64'd18);
    chk("b2b2_prod", 64'(p), 64'hFFFF);
    repeat (20) tick();

    // Asynchronous reset mid-operation
    a8 = 8'd9; b8 = 8'd9; c8 = 8'd0;
    st8 = 1'b1;
    tick();
    st8 = 1'b0;
    repeat (8) tick();
    RSTa = 1'b0;
    #1;
    chk("midrst_prod", 64'(p8), 64'd0);
    chk("midrst_done", 64'(d8), 64'd0);
    chk("midrst_busy", 64'(y8), 64'd0);
    tick();
    RSTa = 1'b1;
    wait8(got, p, n);
    chk("midrst_no_done", 64'(got), 64'd0);
    run8(8'd9, 8'd9, 8'd0, p);
    chk("after_rst_prod", 64'(p), 64'h0051);

    // 32-bit: divider round-trip and extremes
    run32(32'hFFFF_FFF2, 32'd7, 32'hFFFF_FFFE, q);
    chk("rt_m14x7m2", q, 64'hFFFF_FFFF_FFFF_FF9C);
    run32(32'h8000_0000, 32'h8000_0000, 32'd0, q);
    chk("p32_min_x_min", q, 64'h4000_0000_0000_0000);
    run32(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, q);
    chk("p32_min_min_add", q, 64'h4000_0000_7FFF_FFFF);
    run32(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, q);
    chk("p32_max_x_min", q, 64'hC000_0000_0000_0000);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = $urandom;
      run32(ra, rb, rc, q);
      chk("p32_rand", q, ref32(ra, rb, rc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
